// File: rtl/hazard_detect_pkg.sv
// Shared definitions for the hazard detector: request-vector bit positions,
// register-index width, watchdog limit and the shadow-stage record.
package hazard_detect_pkg;

   // Register index width (x0..x31)
   localparam int REG_IDX_W = 5;

   // Bit positions inside haz_vec; bits 5, 1 and 0 are reserved and read as zero
   localparam int HV_DATA = 7;
   localparam int HV_STR  = 6;
   localparam int HV_CTRL = 4;
   localparam int HV_FWRD = 3;
   localparam int HV_CRCT = 2;
   localparam int HV_W    = 8;

   // Watchdog: counter width and the count at which the sticky error is raised
   localparam int               WDOG_W     = 4;
   localparam logic [WDOG_W-1:0] WDOG_LIMIT = 4'd15;

   // Flush counter width; it saturates at all-ones
   localparam int FLUSH_W = 8;

   // One shadow pipeline stage: just enough of the instruction to detect hazards
   typedef struct packed {
      logic                 valid;
      logic [REG_IDX_W-1:0] rd;
      logic                 wr;
      logic                 is_load;
      logic                 is_store;
      logic                 is_branch;
      logic                 pred_taken;
   } stage_t;

   // True when an enabled, nonzero source register is produced by a valid,
   // writing instruction held in the given stage. x0 is hard-wired zero and
   // therefore never a dependency.
   function automatic logic src_match(input logic                 uses,
                                      input logic [REG_IDX_W-1:0] rs,
                                      input stage_t               st);
      return uses && (rs != '0) && st.valid && st.wr && (st.rd == rs);
   endfunction

endpackage

// File: rtl/hazard_detect_stage_reg.sv
// One shadow pipeline stage (EX or MEM). Each cycle it either loads the
// upstream record, loads a bubble, or is cleared by a flush. Only the valid
// bit is reset; the payload is meaningless while valid is low.
module haz_stage_reg
   import hazard_detect_pkg::*;
(
   input  logic   clk_i,
   input  logic   rst_i,
   input  logic   clear_i,
   input  logic   bubble_i,
   input  stage_t stage_i,
   output stage_t stage_o
);

   logic   valid_q, valid_d;
   stage_t payload_q;

   // Valid next-state: clear beats bubble beats a normal load
   always_comb begin
      valid_d = stage_i.valid;
      if (clear_i || bubble_i) begin
         valid_d = 1'b0;
      end
   end

   // Valid bit register with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // Payload follows the upstream stage unconditionally; valid gates its meaning
   always_ff @(posedge clk_i) begin
      payload_q <= stage_i;
   end

   // Recombine the reset-controlled valid with the free-running payload
   always_comb begin
      stage_o       = payload_q;
      stage_o.valid = valid_q;
   end

endmodule

// File: rtl/hazard_detect.sv
// Hazard detector: tracks EX/MEM in a shadow pipeline, raises a registered
// request vector (data / forwardable / structural / control / correct-predict),
// runs a stuck-request watchdog and counts flush cycles.
module hazard_detect
   import hazard_detect_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 id_valid,
   input  logic [REG_IDX_W-1:0] id_rs1,
   input  logic [REG_IDX_W-1:0] id_rs2,
   input  logic [REG_IDX_W-1:0] id_rd,
   input  logic                 id_uses_rs1,
   input  logic                 id_uses_rs2,
   input  logic                 id_wr,
   input  logic                 id_is_load,
   input  logic                 id_is_store,
   input  logic                 id_is_branch,
   input  logic                 id_pred_taken,
   input  logic                 ex_br_taken,
   input  logic                 pc_freeze,
   input  logic                 do_flush,
   input  logic                 resolved,
   output logic [HV_W-1:0]      haz_vec,
   output logic                 stuck,
   output logic [FLUSH_W-1:0]   flush_cnt
);

   stage_t id_stage;
   stage_t ex_q;
   stage_t mem_q;

   logic [HV_W-1:0]    haz_vec_q, haz_vec_d;
   logic [WDOG_W-1:0]  wdog_q, wdog_d;
   logic               stuck_q, stuck_d;
   logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;

   logic match_ex;
   logic match_ex_load;
   logic match_mem;
   logic data_haz;
   logic fwrd_ok;
   logic str_haz;
   logic ctrl_haz;
   logic crct_haz;

   // Pack the ID-stage instruction into a stage record for EX to capture
   always_comb begin
      id_stage            = '0;
      id_stage.valid      = id_valid;
      id_stage.rd         = id_rd;
      id_stage.wr         = id_wr;
      id_stage.is_load    = id_is_load;
      id_stage.is_store   = id_is_store;
      id_stage.is_branch  = id_is_branch;
      id_stage.pred_taken = id_pred_taken;
   end

   // EX: a freeze turns the incoming instruction into a bubble, flush clears it
   haz_stage_reg u_ex (
      .clk_i    (clk),
      .rst_i    (rst),
      .clear_i  (do_flush),
      .bubble_i (pc_freeze),
      .stage_i  (id_stage),
      .stage_o  (ex_q)
   );

   // MEM: keeps draining from EX during a freeze; only a flush clears it
   haz_stage_reg u_mem (
      .clk_i    (clk),
      .rst_i    (rst),
      .clear_i  (do_flush),
      .bubble_i (1'b0),
      .stage_i  (ex_q),
      .stage_o  (mem_q)
   );

   // MEM's class bits are carried for completeness but no hazard term uses them
   logic mem_unused;
   assign mem_unused = ^{mem_q.is_load, mem_q.is_store, mem_q.is_branch, mem_q.pred_taken};

   // Hazard terms from the current ID inputs and shadow stage contents
   always_comb begin
      match_ex      = src_match(id_uses_rs1, id_rs1, ex_q) ||
                      src_match(id_uses_rs2, id_rs2, ex_q);
      match_mem     = src_match(id_uses_rs1, id_rs1, mem_q) ||
                      src_match(id_uses_rs2, id_rs2, mem_q);
      // A load still in EX has no data yet, so a dependency on it cannot be forwarded
      match_ex_load = match_ex && ex_q.is_load;
      data_haz      = id_valid && (match_ex || match_mem);
      fwrd_ok       = data_haz && !match_ex_load;
      // Single memory port: two back-to-back memory operations collide
      str_haz       = id_valid && (id_is_load || id_is_store) &&
                      ex_q.valid && (ex_q.is_load || ex_q.is_store);
      ctrl_haz      = ex_q.valid && ex_q.is_branch;
      crct_haz      = ctrl_haz && (ex_br_taken == ex_q.pred_taken);
   end

   // Assemble the request vector; reserved bits stay zero
   always_comb begin
      haz_vec_d          = '0;
      haz_vec_d[HV_DATA] = data_haz;
      haz_vec_d[HV_STR]  = str_haz;
      haz_vec_d[HV_CTRL] = ctrl_haz;
      haz_vec_d[HV_FWRD] = fwrd_ok;
      haz_vec_d[HV_CRCT] = crct_haz;
   end

   // Watchdog and flush-counter next-state: both saturate, watchdog clears on
   // acknowledgement or when no request is outstanding
   always_comb begin
      wdog_d = wdog_q;
      if (resolved || (haz_vec_q == '0)) begin
         wdog_d = '0;
      end else if (wdog_q != WDOG_LIMIT) begin
         wdog_d = wdog_q + 1'b1;
      end

      stuck_d = stuck_q || (wdog_d == WDOG_LIMIT);

      flush_cnt_d = flush_cnt_q;
      if (do_flush && (flush_cnt_q != {FLUSH_W{1'b1}})) begin
         flush_cnt_d = flush_cnt_q + 1'b1;
      end
   end

   // Control state: request vector, watchdog, sticky flag, flush counter
   always_ff @(posedge clk) begin
      if (rst) begin
         haz_vec_q   <= '0;
         wdog_q      <= '0;
         stuck_q     <= 1'b0;
         flush_cnt_q <= '0;
      end else begin
         haz_vec_q   <= haz_vec_d;
         wdog_q      <= wdog_d;
         stuck_q     <= stuck_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign haz_vec   = haz_vec_q;
   assign stuck     = stuck_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_detect.sv
// Scoreboard bench for hazard_detect: every cycle the expected haz_vec is
// queued with the stimulus and compared one edge later when it is registered.
module tb_hazard_detect;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic       id_uses_rs1, id_uses_rs2, id_wr;
   logic       id_is_load, id_is_store, id_is_branch, id_pred_taken;
   logic       ex_br_taken, pc_freeze, do_flush, resolved;
   logic [7:0] haz_vec;
   logic       stuck;
   logic [7:0] flush_cnt;

   int         checks = 0;
   int         errors = 0;
   int         fc_exp = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   hazard_detect dut (
      .clk           (clk),
      .rst           (rst),
      .id_valid      (id_valid),
      .id_rs1        (id_rs1),
      .id_rs2        (id_rs2),
      .id_rd         (id_rd),
      .id_uses_rs1   (id_uses_rs1),
      .id_uses_rs2   (id_uses_rs2),
      .id_wr         (id_wr),
      .id_is_load    (id_is_load),
      .id_is_store   (id_is_store),
      .id_is_branch  (id_is_branch),
      .id_pred_taken (id_pred_taken),
      .ex_br_taken   (ex_br_taken),
      .pc_freeze     (pc_freeze),
      .do_flush      (do_flush),
      .resolved      (resolved),
      .haz_vec       (haz_vec),
      .stuck         (stuck),
      .flush_cnt     (flush_cnt)
   );

   task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic u1, input logic u2,
                         input logic wr, input logic ld, input logic st,
                         input logic br, input logic pt);
      id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
      id_uses_rs1 = u1; id_uses_rs2 = u2; id_wr = wr;
      id_is_load = ld; id_is_store = st; id_is_branch = br; id_pred_taken = pt;
   endtask

   task automatic idle();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      ex_br_taken = 0; pc_freeze = 0; do_flush = 0; resolved = 0;
   endtask

   task automatic tick();
      if (do_flush && fc_exp < 255) fc_exp++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [7:0] e;
      rst = 1; idle();
      exp_q.push_back(8'h00);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (haz_vec !== e) begin errors++; $display("FAIL reset_hold haz_vec=%h expected=%h", haz_vec, e); end
      rst = 0; fc_exp = 0;
      for (int c = 0; c < 3; c++) begin
         exp_q.push_back(8'h00);
         tick();
         e = exp_q.pop_front();
         checks++;
         if (haz_vec !== e) begin errors++; $display("FAIL reset_idle[%0d] haz_vec=%h expected=%h", c, haz_vec, e); end
      end
      checks++;
      if (stuck !== 1'b0) begin errors++; $display("FAIL reset_stuck stuck=%b expected=0", stuck); end
      checks++;
      if (flush_cnt !== 8'd0) begin errors++; $display("FAIL reset_flush_cnt flush_cnt=%0d expected=0", flush_cnt); end
   endtask

   task automatic test_data_fwd();
      logic [7:0] e, got;
      for (int c = 0; c < 32; c++) begin
         idle();
         e = 8'h00;
         case (c)
            0:  set_id(1, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0);               // add x5
            1:  begin set_id(1, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0); e = 8'h88; end
            4:  set_id(1, 0, 0, 5, 0, 0, 1, 1, 0, 0, 0);               // lw x5
            5:  begin set_id(1, 0, 5, 0, 0, 1, 0, 0, 0, 0, 0); e = 8'h80; end
            8:  set_id(1, 0, 0, 7, 0, 0, 1, 0, 0, 0, 0);
            9:  set_id(1, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0);
            10: begin set_id(1, 7, 0, 0, 1, 0, 0, 0, 0, 0, 0); e = 8'h88; end  // MEM match
            13: set_id(1, 0, 0, 6, 0, 0, 1, 1, 0, 0, 0);
            14: set_id(1, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0);
            15: begin set_id(1, 0, 6, 0, 0, 1, 0, 0, 0, 0, 0); e = 8'h88; end  // load in MEM forwards
            18: set_id(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);               // writes x0
            19: set_id(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);               // reads x0
            20: set_id(1, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0);               // rd=4 without write
            21: set_id(1, 4, 0, 0, 1, 0, 0, 0, 0, 0, 0);
            22: set_id(1, 0, 0, 8, 0, 0, 1, 0, 0, 0, 0);
            23: set_id(0, 8, 0, 0, 1, 0, 0, 0, 0, 0, 0);               // not valid in ID
            25: set_id(1, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0);
            26: set_id(1, 0, 0, 5, 0, 0, 1, 1, 0, 0, 0);
            27: begin set_id(1, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0); e = 8'h80; end  // EX load wins
            28: set_id(1, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0);
            29: set_id(1, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0);               // sources not enabled
            default: ;
         endcase
         exp_q.push_back(e);
         tick();
         got = exp_q.pop_front();
         checks++;
         if (haz_vec !== got) begin errors++; $display("FAIL data_fwd[%0d] haz_vec=%h expected=%h", c, haz_vec, got); end
      end
   endtask

   task automatic test_struct();
      logic [7:0] e, got;
      for (int c = 0; c < 6; c++) begin
         idle();
         e = 8'h00;
         case (c)
            0: set_id(1, 1, 2, 0, 1, 1, 0, 0, 1, 0, 0);                // sw
            1: begin set_id(1, 2, 0, 3, 1, 0, 1, 1, 0, 0, 0); pc_freeze = 1; e = 8'h40; end
            2: set_id(1, 2, 0, 3, 1, 0, 1, 1, 0, 0, 0);                // EX holds bubble
            3: begin set_id(1, 9, 0, 0, 1, 0, 0, 0, 1, 0, 0); e = 8'h40; end  // sw after lw
            default: ;
         endcase
         exp_q.push_back(e);
         tick();
         got = exp_q.pop_front();
         checks++;
         if (haz_vec !== got) begin errors++; $display("FAIL struct[%0d] haz_vec=%h expected=%h", c, haz_vec, got); end
      end
   endtask

   task automatic test_ctrl();
      logic [7:0] e, got;
      for (int c = 0; c < 12; c++) begin
         idle();
         e = 8'h00;
         case (c)
            0: set_id(1, 1, 2, 0, 1, 1, 0, 0, 0, 1, 0);
            1: begin ex_br_taken = 1; e = 8'h10; end
            2: set_id(1, 1, 2, 0, 1, 1, 0, 0, 0, 1, 0);
            3: begin ex_br_taken = 0; e = 8'h14; end
            4: set_id(1, 1, 2, 0, 1, 1, 0, 0, 0, 1, 1);
            5: begin ex_br_taken = 1; e = 8'h14; end
            6: set_id(1, 1, 2, 0, 1, 1, 0, 0, 0, 1, 1);
            7: begin ex_br_taken = 0; e = 8'h10; end
            8: set_id(1, 1, 2, 0, 1, 1, 0, 0, 0, 1, 0);
            9: begin set_id(1, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0); do_flush = 1; e = 8'h14; end
            10: begin set_id(1, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0); ex_br_taken = 1; end
            default: ;
         endcase
         exp_q.push_back(e);
         tick();
         got = exp_q.pop_front();
         checks++;
         if (haz_vec !== got) begin errors++; $display("FAIL ctrl[%0d] haz_vec=%h expected=%h", c, haz_vec, got); end
         if (c == 9) begin
            checks++;
            if (flush_cnt !== 8'd1) begin errors++; $display("FAIL ctrl_flush_cnt flush_cnt=%0d expected=1", flush_cnt); end
         end
      end
   endtask

   task automatic test_flush_freeze();
      logic [7:0] e, got;
      for (int c = 0; c < 8; c++) begin
         idle();
         e = 8'h00;
         case (c)
            0: set_id(1, 0, 0, 9, 0, 0, 1, 0, 0, 0, 0);
            1: begin pc_freeze = 1; do_flush = 1; end                  // flush beats freeze
            2: set_id(1, 9, 0, 0, 1, 0, 0, 0, 0, 0, 0);
            3: set_id(1, 0, 0, 9, 0, 0, 1, 0, 0, 0, 0);
            4: pc_freeze = 1;                                          // MEM still advances
            5: begin set_id(1, 9, 0, 0, 1, 0, 0, 0, 0, 0, 0); e = 8'h88; end
            default: ;
         endcase
         exp_q.push_back(e);
         tick();
         got = exp_q.pop_front();
         checks++;
         if (haz_vec !== got) begin errors++; $display("FAIL flush_freeze[%0d] haz_vec=%h expected=%h", c, haz_vec, got); end
      end
      checks++;
      if (flush_cnt !== fc_exp[7:0]) begin errors++; $display("FAIL flush_freeze_cnt flush_cnt=%0d expected=%0d", flush_cnt, fc_exp); end
   endtask

   task automatic test_watchdog();
      logic [7:0] e, got;
      // resolved in the middle restarts the count, so no stuck after 24 cycles
      for (int c = 0; c < 25; c++) begin
         idle();
         set_id(1, 5, 0, 5, 1, 0, 1, 0, 0, 0, 0);
         if (c == 12) resolved = 1;
         e = (c == 0) ? 8'h00 : 8'h88;
         exp_q.push_back(e);
         tick();
         got = exp_q.pop_front();
         checks++;
         if (haz_vec !== got) begin errors++; $display("FAIL wdog_hold[%0d] haz_vec=%h expected=%h", c, haz_vec, got); end
      end
      checks++;
      if (stuck !== 1'b0) begin errors++; $display("FAIL wdog_resolved stuck=%b expected=0", stuck); end
      // resolved and flush together
      for (int c = 0; c < 5; c++) begin
         idle();
         e = 8'h00;
         if (c == 0) begin set_id(1, 5, 0, 5, 1, 0, 1, 0, 0, 0, 0); resolved = 1; do_flush = 1; e = 8'h88; end
         if (c == 1) set_id(1, 5, 0, 5, 1, 0, 1, 0, 0, 0, 0);
         exp_q.push_back(e);
         tick();
         got = exp_q.pop_front();
         checks++;
         if (haz_vec !== got) begin errors++; $display("FAIL res_flush[%0d] haz_vec=%h expected=%h", c, haz_vec, got); end
      end
      checks++;
      if (flush_cnt !== fc_exp[7:0]) begin errors++; $display("FAIL res_flush_cnt flush_cnt=%0d expected=%0d", flush_cnt, fc_exp); end
      // unresolved hazard: stuck rises after 15 outstanding cycles
      for (int c = 0; c < 20; c++) begin
         idle();
         set_id(1, 5, 0, 5, 1, 0, 1, 0, 0, 0, 0);
         exp_q.push_back((c == 0) ? 8'h00 : 8'h88);
         tick();
         got = exp_q.pop_front();
         checks++;
         if (haz_vec !== got) begin errors++; $display("FAIL stuck_hold[%0d] haz_vec=%h expected=%h", c, haz_vec, got); end
         checks++;
         if (stuck !== (c >= 16)) begin errors++; $display("FAIL stuck_rise[%0d] stuck=%b expected=%b", c, stuck, (c >= 16)); end
      end
      for (int c = 0; c < 4; c++) begin
         idle();
         if (c == 1) resolved = 1;
         exp_q.push_back(8'h00);
         tick();
         got = exp_q.pop_front();
         checks++;
         if (stuck !== 1'b1) begin errors++; $display("FAIL stuck_sticky[%0d] stuck=%b expected=1", c, stuck); end
      end
      rst = 1; idle();
      tick();
      rst = 0; fc_exp = 0;
      checks++;
      if (stuck !== 1'b0) begin errors++; $display("FAIL stuck_reset stuck=%b expected=0", stuck); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] e, got;
      for (int c = 0; c < 5; c++) begin
         idle();
         set_id(1, 5, 0, 5, 1, 0, 1, 0, 0, 0, 0);
         rst = (c == 2);
         if (c == 2) fc_exp = 0;
         e = (c == 1 || c == 4) ? 8'h88 : 8'h00;
         exp_q.push_back(e);
         tick();
         got = exp_q.pop_front();
         checks++;
         if (haz_vec !== got) begin errors++; $display("FAIL reset_mid[%0d] haz_vec=%h expected=%h", c, haz_vec, got); end
      end
      rst = 0;
      for (int i = 1; i <= 300; i++) begin
         idle();
         do_flush = 1;
         exp_q.push_back(8'h00);
         tick();
         got = exp_q.pop_front();
         checks++;
         if (haz_vec !== got) begin errors++; $display("FAIL flood_haz[%0d] haz_vec=%h expected=%h", i, haz_vec, got); end
         if (i == 1 || i == 254 || i == 255 || i == 300) begin
            checks++;
            if (flush_cnt !== fc_exp[7:0]) begin errors++; $display("FAIL flood_cnt[%0d] flush_cnt=%0d expected=%0d", i, flush_cnt, fc_exp); end
         end
      end
      checks++;
      if (flush_cnt !== 8'd255) begin errors++; $display("FAIL flood_sat flush_cnt=%0d expected=255", flush_cnt); end
      idle();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1;
      idle();
      test_reset();
      test_data_fwd();
      test_struct();
      test_ctrl();
      test_flush_freeze();
      test_watchdog();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_detect.md
HAZARD_DETECT -- requirements
Module: hazard_detect

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 id_valid  in  1  instruction present in ID this cycle.
REQ-004 id_rs1, id_rs2, id_rd  in  5 each  source and destination register indices; index 0 never creates a hazard.
REQ-005 id_uses_rs1, id_uses_rs2, id_wr  in  1 each  source-read enables and destination-write enable.
REQ-006 id_is_load, id_is_store, id_is_branch, id_pred_taken  in  1 each  instruction class and static prediction.
REQ-007 ex_br_taken  in  1  actual branch outcome of the branch in EX, valid while EX holds a branch.
REQ-008 pc_freeze, do_flush, resolved  in  1 each  responses from the hazard resolver.
REQ-009 haz_vec  out  8  resolver request vector: [7]=data, [6]=str, [5]=0, [4]=ctrl, [3]=fwrd, [2]=crct, [1:0]=0.
REQ-010 stuck  out  1  sticky watchdog error flag.
REQ-011 flush_cnt  out  8  saturating count of do_flush cycles.

Function
REQ-012 Shadow pipeline: EX and MEM registers, each holding {valid, rd, wr, is_load, is_store, is_branch, pred_taken}.
REQ-013 Normal advance: ID -> EX, EX -> MEM, every cycle with pc_freeze=0 and do_flush=0.
REQ-014 pc_freeze=1: EX loads a bubble (valid=0); MEM still advances from EX; the ID instruction is not captured.
REQ-015 do_flush=1: EX and MEM valid bits cleared next cycle; this takes priority over pc_freeze.
REQ-016 Source match: ID source enabled, nonzero, and equal to the rd of a valid stage with wr=1.
REQ-017 data = id_valid AND a source match against EX or MEM.
REQ-018 fwrd = data AND no source match against an EX entry with is_load=1; a load-use in EX is never forwardable.
REQ-019 str = id_valid AND (id_is_load OR id_is_store) AND EX valid AND (EX is_load OR EX is_store); single memory port.
REQ-020 ctrl = EX valid AND EX is_branch.
REQ-021 crct = ctrl AND (ex_br_taken == EX pred_taken); crct=0 while ctrl=0.
REQ-022 haz_vec is registered: it reflects the ID/EX/MEM contents sampled at edge N and is visible after edge N (latency 1); all undefined bits are 0.
REQ-023 Watchdog: a 4-bit counter increments while haz_vec is nonzero and resolved=0, and clears when resolved=1 or haz_vec=0.
REQ-024 The watchdog counter reaching 15 sets stuck=1; the counter saturates at 15, and stuck holds until reset.
REQ-025 flush_cnt increments on each cycle with do_flush=1 and saturates at 255.
REQ-026 When resolved=1 and do_flush=1 arrive in the same cycle, the flush is applied and the watchdog clears.

Reset
REQ-027 While rst=1 at an edge: EX and MEM valid bits=0, haz_vec=8'h00, stuck=0, flush_cnt=0, watchdog counter=0.
REQ-028 A reset asserted mid-operation discards all in-flight state; the first non-zero haz_vec can appear no earlier than the second edge after rst falls.

Structure
REQ-029 A shared package holds the haz_vec bit-position constants (DATA=7, STR=6, CTRL=4, FWRD=3, CRCT=2), the register-index width of 5, and the watchdog limit of 15.
REQ-030 One sub-module, haz_stage_reg, implements a single shadow pipeline stage (load, bubble and clear) and is instantiated twice, for EX and MEM.

Verification
REQ-031 Reset followed by 3 idle cycles -> haz_vec=00, stuck=0, flush_cnt=0.
REQ-032 Non-load writing x5 in EX, then ID reads x5 -> haz_vec=8'h88 (data+fwrd); the same sequence with an EX load -> haz_vec=8'h80.
REQ-033 EX store with an ID load -> haz_vec=8'h40; after pc_freeze, EX holds a bubble and str=0 on the next sample.
REQ-034 EX branch with pred_taken=0 and ex_br_taken=1 -> haz_vec=8'h10; with ex_br_taken=0 -> haz_vec=8'h14. A do_flush pulse then clears EX/MEM and increments flush_cnt to 1.
REQ-035 Hold a data hazard with resolved=0 for 15 cycles -> stuck=1, which persists after the hazard clears until rst.
REQ-036 Assert rst mid-hazard -> haz_vec=00 the next cycle; 300 do_flush cycles -> flush_cnt=255.
